// File: rtl/timer_loader_nivel2_pkg.sv
// Shared types and constants for the nivel2 timer loader.
// Digit width, digit count, FSM states and the quickstart preset.
package timer_nivel2_pkg;

  localparam int DATA_W   = 4;
  localparam int NDIG     = 3;
  localparam int MAX_TENS = 5;

  typedef logic [DATA_W-1:0] digit_t;
  typedef logic [1:0]        phase_t;

  localparam digit_t KEY_CLEAR  = 4'd10;
  localparam digit_t QS_MIN     = 4'd0;
  localparam digit_t QS_TENS    = 4'd3;
  localparam digit_t QS_UNITS   = 4'd0;
  localparam phase_t LAST_PHASE = phase_t'(NDIG - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_SEND,
    ST_RUN,
    ST_PAUSED
  } state_e;

  function automatic logic is_digit(digit_t k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/timer_loader_nivel2_if.sv
// Keypad, control and timer-load signals of the nivel2 loader.
// slave = loader side, master = keypad/timer side.
interface timer_loader_nivel2_if;
  import timer_nivel2_pkg::*;

  digit_t key_code;
  logic   key_valid;
  logic   start;
  logic   stop;
  logic   timer_done;
  digit_t data;
  logic   loadn;
  logic   enable;
  digit_t buf_min;
  digit_t buf_tens;
  digit_t buf_units;
  logic   busy;
  logic   err;

  modport slave (
    input  key_code, key_valid, start, stop, timer_done,
    output data, loadn, enable,
    output buf_min, buf_tens, buf_units, busy, err
  );

  modport master (
    output key_code, key_valid, start, stop, timer_done,
    input  data, loadn, enable,
    input  buf_min, buf_tens, buf_units, busy, err
  );

endinterface

// File: rtl/timer_loader_nivel2_bcd_entry_buffer.sv
// Three-digit BCD entry buffer with saturating count,
// synchronous clear, preset load and M:SS validity flag.
module bcd_entry_buffer
  import timer_nivel2_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear_i,
  input  logic   preset_i,
  input  logic   shift_i,
  input  digit_t digit_i,
  output digit_t min_o,
  output digit_t tens_o,
  output digit_t units_o,
  output logic   valid_o,
  output logic   zero_o
);

  digit_t     min_q, min_d;
  digit_t     tens_q, tens_d;
  digit_t     units_q, units_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    min_d   = min_q;
    tens_d  = tens_q;
    units_d = units_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      clear_i: begin
        min_d   = '0;
        tens_d  = '0;
        units_d = '0;
        cnt_d   = '0;
      end
      preset_i: begin
        min_d   = QS_MIN;
        tens_d  = QS_TENS;
        units_d = QS_UNITS;
        cnt_d   = 2'd3;
      end
      shift_i: begin
        min_d   = tens_q;
        tens_d  = units_q;
        units_d = digit_i;
        cnt_d   = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q   <= '0;
      tens_q  <= '0;
      units_q <= '0;
      cnt_q   <= '0;
    end else begin
      min_q   <= min_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      cnt_q   <= cnt_d;
    end
  end

  assign min_o   = min_q;
  assign tens_o  = tens_q;
  assign units_o = units_q;
  assign zero_o  = ({min_q, tens_q, units_q} == '0);
  assign valid_o = (tens_q <= digit_t'(MAX_TENS)) && !zero_o;

endmodule

// File: rtl/timer_loader_nivel2.sv
// Keypad front end and load sequencer for the nivel2 timer.
// Optional TIMER_QUICKSTART_EN: start on an empty entry loads 0:30.
module timer_loader_nivel2
  import timer_nivel2_pkg::*;
(
  input logic                  clk,
  input logic                  clearn,
  timer_loader_nivel2_if.slave bus
);

  state_e state_q, state_d;
  phase_t phase_q, phase_d;
  digit_t data_q, data_d;
  logic   loadn_q, loadn_d;
  logic   enable_q, enable_d;
  logic   busy_q, busy_d;
  logic   err_q, err_d;

  logic   buf_clr, buf_qs, buf_shift;
  digit_t b_min, b_tens, b_units;
  logic   b_valid, b_zero;
  logic   key_dig, key_clr, go;

  assign key_dig = bus.key_valid && is_digit(bus.key_code);
  assign key_clr = bus.key_valid && (bus.key_code == KEY_CLEAR);
  assign go      = bus.start && !bus.stop;

  bcd_entry_buffer u_buf (
    .clk      (clk),
    .rst_n    (clearn),
    .clear_i  (buf_clr),
    .preset_i (buf_qs),
    .shift_i  (buf_shift),
    .digit_i  (bus.key_code),
    .min_o    (b_min),
    .tens_o   (b_tens),
    .units_o  (b_units),
    .valid_o  (b_valid),
    .zero_o   (b_zero)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    buf_clr   = 1'b0;
    buf_qs    = 1'b0;
    buf_shift = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (go) begin
`ifdef TIMER_QUICKSTART_EN
          if (b_zero) begin
            buf_qs  = 1'b1;
            state_d = ST_SEND;
            phase_d = '0;
          end else
`endif
          if (b_valid) begin
            state_d = ST_SEND;
            phase_d = '0;
          end else begin
            err_d   = 1'b1;
            buf_clr = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (!bus.start) begin
          // a start strobe, even a suppressed one, drops the key
          if (key_clr) begin
            buf_clr = 1'b1;
            state_d = ST_IDLE;
          end else if (key_dig) begin
            buf_shift = 1'b1;
            state_d   = ST_ENTRY;
          end
        end
      end
      ST_SEND: begin
        if (phase_q == LAST_PHASE) begin
          state_d = ST_RUN;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      ST_RUN: begin
        if (bus.timer_done) begin
          buf_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.stop) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (bus.stop) begin
          buf_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.start) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d  = '0;
    loadn_d = 1'b1;
    if (state_q == ST_SEND) begin
      loadn_d = 1'b0;
      unique case (1'b1)
        (phase_q == 2'd0): data_d = b_min;
        (phase_q == 2'd1): data_d = b_tens;
        default:           data_d = b_units;
      endcase
    end
    // enable follows the run state, but only once the load is complete
    enable_d = (state_d == ST_RUN) &&
               (state_q == ST_RUN || state_q == ST_PAUSED);
    busy_d   = state_d inside {ST_SEND, ST_RUN, ST_PAUSED};
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      data_q   <= '0;
      loadn_q  <= 1'b1;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      data_q   <= data_d;
      loadn_q  <= loadn_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.loadn     = loadn_q;
  assign bus.enable    = enable_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.buf_min   = b_min;
  assign bus.buf_tens  = b_tens;
  assign bus.buf_units = b_units;

endmodule

// File: tb/tb_timer_loader_nivel2.sv
// Bench for timer_loader_nivel2: directed steps plus random keys,
// checked every cycle against a decimal-arithmetic reference model.
module tb_timer_loader_nivel2;
  import timer_nivel2_pkg::*;

`ifdef TIMER_QUICKSTART_EN
  localparam bit QS = 1'b1;
`else
  localparam bit QS = 1'b0;
`endif

  localparam int M_EDIT  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;

  logic clk = 1'b0;
  logic clearn = 1'b0;
  always #5 clk = ~clk;

  timer_loader_nivel2_if bus ();

  timer_loader_nivel2 dut (
    .clk    (clk),
    .clearn (clearn),
    .bus    (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  int mval;
  int mode;
  int ld;
  int e_data;
  logic e_loadn, e_enable, e_err;

  function automatic int dig(int v, int i);
    if (i == 0) return v / 100;
    if (i == 1) return (v / 10) % 10;
    return v % 10;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mval     = 0;
    mode     = M_EDIT;
    ld       = 0;
    e_data   = 0;
    e_loadn  = 1'b1;
    e_enable = 1'b0;
    e_err    = 1'b0;
  endtask

  task automatic model_edge(input logic kv, input logic [3:0] kc,
                            input logic st, input logic sp,
                            input logic td);
    e_err    = 1'b0;
    e_loadn  = 1'b1;
    e_data   = 0;
    e_enable = 1'b0;
    case (mode)
      M_EDIT: begin
        if (st && !sp) begin
          if (QS && mval == 0) begin
            mval = 30;
            mode = M_LOAD;
            ld   = 0;
          end else if (mval == 0 || dig(mval, 1) > MAX_TENS) begin
            e_err = 1'b1;
            mval  = 0;
          end else begin
            mode = M_LOAD;
            ld   = 0;
          end
        end else if (!st && kv) begin
          if (kc == 4'd10) mval = 0;
          else if (kc < 4'd10) mval = (mval * 10 + int'(kc)) % 1000;
        end
      end
      M_LOAD: begin
        ld++;
        e_loadn = 1'b0;
        e_data  = dig(mval, ld - 1);
        if (ld == NDIG) mode = M_RUN;
      end
      M_RUN: begin
        if (td) begin
          mode = M_EDIT;
          mval = 0;
        end else if (sp) begin
          mode = M_PAUSE;
        end else begin
          e_enable = 1'b1;
        end
      end
      default: begin
        if (sp) begin
          mode = M_EDIT;
          mval = 0;
        end else if (st) begin
          mode     = M_RUN;
          e_enable = 1'b1;
        end
      end
    endcase
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".data"},   bus.data,            4'(e_data));
    chk({ph, ".loadn"},  4'(bus.loadn),       4'(e_loadn));
    chk({ph, ".enable"}, 4'(bus.enable),      4'(e_enable));
    chk({ph, ".err"},    4'(bus.err),         4'(e_err));
    chk({ph, ".busy"},   4'(bus.busy),        4'(mode != M_EDIT));
    chk({ph, ".min"},    bus.buf_min,         4'(dig(mval, 0)));
    chk({ph, ".tens"},   bus.buf_tens,        4'(dig(mval, 1)));
    chk({ph, ".units"},  bus.buf_units,       4'(dig(mval, 2)));
  endtask

  task automatic step(input string ph, input logic kv,
                      input logic [3:0] kc, input logic st,
                      input logic sp, input logic td);
    bus.key_valid  = kv;
    bus.key_code   = kc;
    bus.start      = st;
    bus.stop       = sp;
    bus.timer_done = td;
    model_edge(kv, kc, st, sp, td);
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic key(input string ph, input logic [3:0] d);
    step(ph, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input string ph, input int n);
    for (int i = 0; i < n; i++) step(ph, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.key_valid  = 1'b0;
    bus.key_code   = '0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.timer_done = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    clearn = 1'b1;

    key("k200", 4'd2); key("k200", 4'd0); key("k200", 4'd0);
    step("start200", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle("send200", 5);
    step("done200", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle("after200", 1);

    key("k1234", 4'd1); key("k1234", 4'd2);
    key("k1234", 4'd3); key("k1234", 4'd4);
    key("clear", KEY_CLEAR);
    idle("cleared", 1);

    key("k175", 4'd1); key("k175", 4'd7); key("k175", 4'd5);
    step("start175", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle("err175", 2);

    key("k130", 4'd1); key("k130", 4'd3); key("k130", 4'd0);
    step("start130", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle("run130", 5);
    step("pause", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    idle("paused", 2);
    step("resume", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle("resumed", 2);
    step("stop1", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step("stop2", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    idle("cancel", 1);

    key("k45", 4'd4); key("k45", 4'd5);
    step("start45", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle("run45", 5);
    step("done_stop", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    idle("after45", 1);

    step("start_idle", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle("qs", 6);
    step("qs_done", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    key("k123", 4'd1); key("k123", 4'd2); key("k123", 4'd3);
    step("start123", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle("send123", 2);
    #1;
    clearn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    clearn = 1'b1;
    idle("post_rst", 1);

    for (int i = 0; i < 600; i++) begin
      logic       kv, st, sp, td;
      logic [3:0] kc;
      kv = ($urandom_range(0, 2) == 0);
      kc = 4'($urandom_range(0, 12));
      st = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 11) == 0);
      td = ($urandom_range(0, 13) == 0);
      step("rand", kv, kc, st, sp, td);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
